// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared constants for the multiplexed seven-segment scan controller.
package seven_seg_scan_ctrl_pkg;

    // Reset is active-low: the design is held in reset while rst equals this value.
    localparam logic RST_ACTIVE = 1'b0;

    // One UART byte carries two hex digits.
    localparam int HEX_BYTE_W = 8;
    localparam int NIBBLE_W   = 4;

    // Defaults sized for a ~50 MHz clock and a ~1 kHz digit scan.
    localparam int DEF_DIGITS       = 4;
    localparam int DEF_SCAN_DIV     = 50000;
    localparam int DEF_BLANK_CYCLES = 64;

endpackage

// File: rtl/seven_seg_scan_ctrl_tick_gen.sv
// Prescaler and digit-slot index for the display scan.
// slot_wrap marks the last cycle of a slot, frame_wrap the last cycle of the
// last slot, and in_blank the leading part of each slot where selects stay off.
module scan_tick_gen
    import seven_seg_scan_ctrl_pkg::*;
#(
    parameter int DIGITS       = DEF_DIGITS,
    parameter int SCAN_DIV     = DEF_SCAN_DIV,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
    localparam int PRESC_W     = $clog2(SCAN_DIV),
    localparam int IDX_W       = $clog2(DIGITS)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [IDX_W-1:0] idx,
    output logic             in_blank,
    output logic             slot_wrap,
    output logic             frame_wrap
);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    assign slot_wrap  = (presc_q == PRESC_W'(SCAN_DIV - 1));
    assign frame_wrap = slot_wrap && (idx_q == IDX_W'(DIGITS - 1));
    assign in_blank   = (presc_q < PRESC_W'(BLANK_CYCLES));
    assign idx        = idx_q;

    // Next prescaler and slot index: wrap the prescaler, step the slot on wrap.
    always_comb begin
        presc_d = presc_q + PRESC_W'(1);
        idx_d   = idx_q;
        if (slot_wrap) begin
            presc_d = '0;
            if (frame_wrap) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Prescaler and slot index registers.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller.
// Bytes from the UART path shift into a shadow buffer; the shadow is copied
// to the displayed buffer only at a frame boundary so a frame never mixes old
// and new digits. Each slot puts one nibble on num for the registered
// hex-to-segment converter, and digit_sel is delayed one extra cycle so it
// lines up with the converter output. Selects are held off at the start of
// every slot to avoid ghosting.
//
// Handshake: a byte transfers on a rising clk edge where in_valid and
// in_ready are both high. in_ready depends only on rst and in_clr, never on
// in_valid, and the sender must hold in_data stable while in_valid is high
// and in_ready is low.
module seven_seg_scan_ctrl
    import seven_seg_scan_ctrl_pkg::*;
#(
    parameter int DIGITS       = DEF_DIGITS,
    parameter int SCAN_DIV     = DEF_SCAN_DIV,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [HEX_BYTE_W-1:0] in_data,
    input  logic                  in_clr,
    output logic [NIBBLE_W-1:0]   num,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  frame_start,
    output logic                  pending
);

    localparam int BUF_W = DIGITS * NIBBLE_W;
    localparam int IDX_W = $clog2(DIGITS);

    logic [IDX_W-1:0] idx;
    logic             in_blank;
    logic             slot_wrap;
    logic             frame_wrap;

    scan_tick_gen #(
        .DIGITS       (DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_tick (
        .clk        (clk),
        .rst        (rst),
        .idx        (idx),
        .in_blank   (in_blank),
        .slot_wrap  (slot_wrap),
        .frame_wrap (frame_wrap)
    );

    logic [BUF_W-1:0]    shadow_q, shadow_d;
    logic [BUF_W-1:0]    display_q, display_d;
    logic                pending_q, pending_d;
    logic                frame_start_q;
    logic [NIBBLE_W-1:0] num_q, num_d;
    logic [DIGITS-1:0]   sel_s1_q, sel_s1_d;
    logic [DIGITS-1:0]   digit_sel_q;
    logic [BUF_W-1:0]    shadow_shifted;
    logic                accept;
    logic                frame_commit;

    assign in_ready     = (rst != RST_ACTIVE) && !in_clr;
    assign accept       = in_valid && in_ready;
    // frame_wrap already implies slot_wrap; qualifying keeps the commit on a slot edge.
    assign frame_commit = frame_wrap && slot_wrap;

    // New byte enters the two lowest digits; the oldest byte falls off the top.
    generate
        if (DIGITS == 2) begin : g_shift_two
            assign shadow_shifted = in_data;
        end else begin : g_shift_wide
            assign shadow_shifted = {shadow_q[BUF_W-HEX_BYTE_W-1:0], in_data};
        end
    endgenerate

    // Buffer update: clear wins over write, commit copies the pre-write shadow.
    always_comb begin
        shadow_d  = shadow_q;
        display_d = display_q;
        pending_d = pending_q;
        if (frame_commit) begin
            display_d = shadow_q;
            pending_d = 1'b0;
        end
        if (in_clr) begin
            shadow_d  = '0;
            pending_d = 1'b1;
        end else if (accept) begin
            shadow_d  = shadow_shifted;
            pending_d = 1'b1;
        end
    end

    // Pipeline stage 1: nibble for the current slot and its un-delayed select.
    always_comb begin
        num_d    = '0;
        sel_s1_d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                num_d       = display_q[i*NIBBLE_W +: NIBBLE_W];
                sel_s1_d[i] = !in_blank;
            end
        end
    end

    // Buffers, frame pulse and the output pipeline registers.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            shadow_q      <= '0;
            display_q     <= '0;
            pending_q     <= 1'b0;
            frame_start_q <= 1'b0;
            num_q         <= '0;
            sel_s1_q      <= '0;
            digit_sel_q   <= '0;
        end else begin
            shadow_q      <= shadow_d;
            display_q     <= display_d;
            pending_q     <= pending_d;
            frame_start_q <= frame_commit;
            num_q         <= num_d;
            sel_s1_q      <= sel_s1_d;
            digit_sel_q   <= sel_s1_q;
        end
    end

    assign num         = num_q;
    assign digit_sel   = digit_sel_q;
    assign frame_start = frame_start_q;
    assign pending     = pending_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
// cyc counts rising edges since reset release; outputs are sampled on the
// falling edge, when cyc already reflects the last rising edge.
module tb_seven_seg_scan_ctrl;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_clr;
    logic [3:0] num;
    logic [3:0] digit_sel;
    logic       frame_start;
    logic       pending;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    seven_seg_scan_ctrl #(
        .DIGITS       (4),
        .SCAN_DIV     (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_clr      (in_clr),
        .num         (num),
        .digit_sel   (digit_sel),
        .frame_start (frame_start),
        .pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // digit_sel after n edges reflects slot position at edge n-2.
    function automatic logic [3:0] exp_sel(input int n);
        int m;
        if (n < 2) return 4'b0000;
        m = n - 2;
        if ((m % 8) >= 2) return 4'b0001 << ((m / 8) % 4);
        return 4'b0000;
    endfunction

    function automatic logic exp_fs(input int n);
        return (n > 0) && ((n % 32) == 0);
    endfunction

    // Advance to edge count n, checking the scan pattern at every sample.
    task automatic wait_to(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 1000) begin
            @(negedge clk);
            guard++;
            chk("digit_sel", 32'(digit_sel), 32'(exp_sel(cyc)));
            chk("frame_start", 32'(frame_start), 32'(exp_fs(cyc)));
            chk("sel_onehot", 32'($countones(digit_sel) <= 1), 32'd1);
        end
        if (guard >= 1000) begin
            checks++;
            errors++;
            $error("FAIL wait_timeout observed=%0d expected=%0d", cyc, n);
        end
    endtask

    task automatic num_at(input int n, input logic [3:0] exp);
        wait_to(n);
        chk("num", 32'(num), 32'(exp));
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_clr   = 1'b0;

        // Reset state
        #1;
        chk("rst_num", 32'(num), 32'd0);
        chk("rst_sel", 32'(digit_sel), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // 1: idle scan, blank display
        for (int n = 1; n <= 40; n++) num_at(n, 4'h0);
        chk("idle_pending", 32'(pending), 32'd0);

        // 2: two bytes mid-frame, committed at edge 64
        wait_to(41);
        in_valid = 1'b1; in_data = 8'h12;
        wait_to(42);
        in_data = 8'h34;
        wait_to(43);
        in_valid = 1'b0;
        chk("t2_pending_set", 32'(pending), 32'd1);
        num_at(63, 4'h0);
        wait_to(64);
        chk("t2_pending_clr", 32'(pending), 32'd0);
        num_at(66, 4'h4);
        num_at(74, 4'h3);
        num_at(82, 4'h2);
        num_at(90, 4'h1);

        // 3: write on the frame-wrap edge (128)
        wait_to(100);
        in_valid = 1'b1; in_data = 8'h56;
        wait_to(101);
        in_valid = 1'b0;
        chk("t3_pending_a", 32'(pending), 32'd1);
        wait_to(127);
        in_valid = 1'b1; in_data = 8'hAB;
        wait_to(128);
        in_valid = 1'b0;
        chk("t3_pending_kept", 32'(pending), 32'd1);
        num_at(130, 4'h6);
        num_at(138, 4'h5);
        num_at(146, 4'h4);
        num_at(154, 4'h3);
        wait_to(160);
        chk("t3_pending_clr", 32'(pending), 32'd0);
        num_at(162, 4'hB);
        num_at(170, 4'hA);
        num_at(178, 4'h6);
        num_at(186, 4'h5);

        // 4: clear blocks a simultaneous byte; byte taken once clear drops (edge 192 = frame wrap)
        wait_to(190);
        in_clr = 1'b1; in_valid = 1'b1; in_data = 8'h55;
        #1;
        chk("t4_ready_low", 32'(in_ready), 32'd0);
        wait_to(191);
        chk("t4_pending_clr", 32'(pending), 32'd1);
        in_clr = 1'b0;
        #1;
        chk("t4_ready_high", 32'(in_ready), 32'd1);
        wait_to(192);
        in_valid = 1'b0;
        chk("t4_pending_kept", 32'(pending), 32'd1);
        num_at(194, 4'h0);
        num_at(202, 4'h0);
        wait_to(224);
        chk("t4_pending_done", 32'(pending), 32'd0);
        num_at(226, 4'h5);

        // 5: asynchronous reset mid-slot
        wait_to(227);
        in_valid = 1'b1; in_data = 8'h77;
        wait_to(228);
        in_valid = 1'b0;
        chk("t5_pending_pre", 32'(pending), 32'd1);
        chk("t5_num_pre", 32'(num), 32'h5);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_num", 32'(num), 32'd0);
        chk("t5_sel", 32'(digit_sel), 32'd0);
        chk("t5_fs", 32'(frame_start), 32'd0);
        chk("t5_pending", 32'(pending), 32'd0);
        chk("t5_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int n = 1; n <= 40; n++) num_at(n, 4'h0);
        chk("t5_pending_after", 32'(pending), 32'd0);

        // 6: ten back-to-back bytes 0x01..0x0A
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            #1;
            chk("t6_ready", 32'(in_ready), 32'd1);
            wait_to(40 + i);
        end
        in_valid = 1'b0;
        chk("t6_pending", 32'(pending), 32'd1);
        num_at(63, 4'h0);
        wait_to(64);
        chk("t6_pending_clr", 32'(pending), 32'd0);
        num_at(66, 4'hA);
        num_at(74, 4'h0);
        num_at(82, 4'h9);
        num_at(90, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
